// File: rtl/ttl_pkg.sv
// Shared types and limits for the TTL recreation gate/monostable blocks.
package ttl_pkg;

    typedef enum logic {
        OS_IDLE   = 1'b0,
        OS_ACTIVE = 1'b1
    } os_state_e;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_DELAY = 4;
    localparam int MAX_PULSE = 255;

endpackage

// File: rtl/ttl_oneshot.sv
// Clock-enabled one-shot (74121 / 74123 style); pulse_n is low for PULSE_LEN
// enabled cycles after a trigger, optionally retriggerable.
module ttl_oneshot
    import ttl_pkg::*;
#(
    parameter int PULSE_LEN = 1,
    parameter bit RETRIG    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic trig,
    output logic pulse_n,
    output logic busy
);

    if (PULSE_LEN < 0 || PULSE_LEN > MAX_PULSE) begin : g_bad_pulse
        $error("ttl_oneshot: PULSE_LEN %0d out of range 0..%0d", PULSE_LEN, MAX_PULSE);
    end

    if (PULSE_LEN == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst_n, en, trig};
        assign pulse_n = 1'b1;
        assign busy    = 1'b0;
    end else begin : g_on
        localparam int CW       = ($clog2(PULSE_LEN + 1) > 1) ? $clog2(PULSE_LEN + 1) : 1;
        localparam int RELOAD_I = PULSE_LEN - 1;
        localparam logic [CW-1:0] RELOAD = RELOAD_I[CW-1:0];

        os_state_e     state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          fire;

        // Triggers only count on enabled cycles, so a free-running trig is safe.
        assign fire = en & trig;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                OS_IDLE: begin
                    if (fire) begin
                        state_d = OS_ACTIVE;
                        cnt_d   = RELOAD;
                    end
                end
                OS_ACTIVE: begin
                    // A retrigger wins over both decrement and expiry.
                    if (fire && RETRIG) begin
                        cnt_d = RELOAD;
                    end else if (en) begin
                        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                        else             state_d = OS_IDLE;
                    end
                end
                default: state_d = OS_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= OS_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign busy    = (state_q == OS_ACTIVE);
        assign pulse_n = ~busy;
    end

endmodule

// File: rtl/ttl_nand_match.sv
// Wide NAND/AND term detector with per-input inversion, enabled delay pipeline
// and a one-shot fired on each rising edge of the delayed match.
module ttl_nand_match
    import ttl_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] INV_MASK  = '0,
    parameter int               DELAY     = 1,
    parameter int               PULSE_LEN = 1,
    parameter bit               RETRIG    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic             y,
    output logic             match,
    output logic             pulse_n,
    output logic             busy
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("ttl_nand_match: WIDTH %0d out of range 2..%0d", WIDTH, MAX_WIDTH);
    end
    if (DELAY < 0 || DELAY > MAX_DELAY) begin : g_bad_delay
        $error("ttl_nand_match: DELAY %0d out of range 0..%0d", DELAY, MAX_DELAY);
    end

    logic             t;
    logic [DELAY:0]   stage;   // stage[0] is the live term, stage[DELAY] the output
    logic             m_prev_q, m_prev_d;
    logic             rise;

    assign t        = &(in ^ INV_MASK);
    assign stage[0] = t;

    if (DELAY > 0) begin : g_pipe
        logic [DELAY:1] pipe_q, pipe_d;

        always_comb begin
            pipe_d = pipe_q;
            if (en) pipe_d = stage[DELAY-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pipe_q <= '0;
            else        pipe_q <= pipe_d;
        end

        assign stage[DELAY:1] = pipe_q;
    end

    assign match = stage[DELAY];
    assign y     = ~match;

    // Edge history is cleared by reset, so a match present at power-up fires.
    always_comb begin
        m_prev_d = m_prev_q;
        if (en) m_prev_d = match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_prev_q <= 1'b0;
        else        m_prev_q <= m_prev_d;
    end

    assign rise = en & match & ~m_prev_q;

    ttl_oneshot #(
        .PULSE_LEN (PULSE_LEN),
        .RETRIG    (RETRIG)
    ) u_oneshot (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .trig    (rise),
        .pulse_n (pulse_n),
        .busy    (busy)
    );

endmodule

// File: tb/tb_ttl_nand_match.sv
// Bench for ttl_nand_match: five configurations share one input bus and are
// compared every cycle against a pulse-budget model, plus directed sequences.
module tb_ttl_nand_match;

    localparam int N = 5;
    // 0:A  1:B  2:C  3:D  4:E
    localparam logic [7:0] P_INV [N] = '{8'h00, 8'h0F, 8'hA5, 8'h00, 8'h0F};
    localparam int         P_DLY [N] = '{1, 0, 4, 1, 0};
    localparam int         P_PL  [N] = '{4, 4, 0, 10, 4};
    localparam bit         P_RT  [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic [7:0]   din = 8'h00;
    logic [N-1:0] y_w, m_w, pn_w, bz_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ttl_nand_match #(.WIDTH(8), .INV_MASK(8'h00), .DELAY(1), .PULSE_LEN(4),  .RETRIG(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .y(y_w[0]), .match(m_w[0]), .pulse_n(pn_w[0]), .busy(bz_w[0]));
    ttl_nand_match #(.WIDTH(8), .INV_MASK(8'h0F), .DELAY(0), .PULSE_LEN(4),  .RETRIG(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .y(y_w[1]), .match(m_w[1]), .pulse_n(pn_w[1]), .busy(bz_w[1]));
    ttl_nand_match #(.WIDTH(8), .INV_MASK(8'hA5), .DELAY(4), .PULSE_LEN(0),  .RETRIG(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .y(y_w[2]), .match(m_w[2]), .pulse_n(pn_w[2]), .busy(bz_w[2]));
    ttl_nand_match #(.WIDTH(8), .INV_MASK(8'h00), .DELAY(1), .PULSE_LEN(10), .RETRIG(1'b0)) u_d (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .y(y_w[3]), .match(m_w[3]), .pulse_n(pn_w[3]), .busy(bz_w[3]));
    ttl_nand_match #(.WIDTH(8), .INV_MASK(8'h0F), .DELAY(0), .PULSE_LEN(4),  .RETRIG(1'b0)) u_e (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .y(y_w[4]), .match(m_w[4]), .pulse_n(pn_w[4]), .busy(bz_w[4]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: history of the term per enabled tick, and the number of
    // enabled cycles the pulse still has to stay low.
    logic [3:0] hist  [N];
    logic       mprev [N];
    int         rem   [N];

    function automatic logic mdl_match(int k);
        if (P_DLY[k] == 0) return ((din ^ P_INV[k]) == 8'hFF);
        return hist[k][P_DLY[k]-1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic mt, rs;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                hist[k]  <= '0;
                mprev[k] <= 1'b0;
                rem[k]   <= 0;
            end
        end else if (en) begin
            for (int k = 0; k < N; k++) begin
                mt = mdl_match(k);
                rs = mt & ~mprev[k];
                if (rem[k] > 0)                rem[k] <= (rs && P_RT[k]) ? P_PL[k] : rem[k] - 1;
                else if (rs && P_PL[k] > 0)    rem[k] <= P_PL[k];
                hist[k]  <= {hist[k][2:0], ((din ^ P_INV[k]) == 8'hFF)};
                mprev[k] <= mt;
            end
        end
    end

    logic c_low_seen = 1'b0;

    always @(negedge clk) begin
        logic em;
        for (int k = 0; k < N; k++) begin
            em = mdl_match(k);
            chk($sformatf("model inst%0d {y,match,pulse_n,busy}", k),
                {28'd0, y_w[k], m_w[k], pn_w[k], bz_w[k]},
                {28'd0, ~em, em, (rem[k] == 0), (rem[k] != 0)});
        end
        c_low_seen <= c_low_seen | ~pn_w[2] | bz_w[2];
    end

    typedef struct {
        logic [7:0] din;
        logic       en;
        logic       y_a;
        logic       pn_a;
        logic       y_b;
    } vec_t;

    vec_t vt [9];

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lo_a, lo_b, lo_e, falls;
        logic prev;

        vt[0] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{8'hFE, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[3] = '{8'hFE, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[8] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};

        cycles(3);
        chk("reset y_a", y_w[0], 1'b1);
        chk("reset match_a", m_w[0], 1'b0);
        chk("reset pulse_n_a", pn_w[0], 1'b1);
        chk("reset busy_d", bz_w[3], 1'b0);
        rst_n = 1'b1;
        cycles(1);

        din = 8'hFF; #1;
        chk("y_a before first edge", y_w[0], 1'b1);

        for (int i = 0; i < 9; i++) begin
            din = vt[i].din;
            en  = vt[i].en;
            cycles(1);
            chk($sformatf("vec%0d y_a", i), y_w[0], vt[i].y_a);
            chk($sformatf("vec%0d pulse_n_a", i), pn_w[0], vt[i].pn_a);
            chk($sformatf("vec%0d y_b", i), y_w[1], vt[i].y_b);
        end

        // DELAY=0 path is purely combinational.
        din = 8'hF0; #1;
        chk("comb y_b in=F0", y_w[1], 1'b0);
        din = 8'hFF; #1;
        chk("comb y_b in=FF", y_w[1], 1'b1);

        // Level held for 20 cycles: one pulse of four cycles.
        din = 8'h00; cycles(8);
        din = 8'hFF; falls = 0; lo_a = 0; prev = pn_w[0];
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (prev && !pn_w[0]) falls++;
            if (!pn_w[0]) lo_a++;
            prev = pn_w[0];
        end
        chk("held match pulse count", falls, 1);
        chk("held match low cycles", lo_a, 4);

        // en toggling stretches the pulse in clk time.
        din = 8'h00; cycles(6);
        din = 8'hFF; lo_a = 0;
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 0);
            cycles(1);
            if (!pn_w[0]) lo_a++;
        end
        en = 1'b1;
        chk("en 1-0-1-0 low clk cycles", lo_a, 8);

        // Second rise two cycles into the pulse: retrig vs not.
        din = 8'h00; cycles(6);
        lo_b = 0; lo_e = 0;
        for (int i = 0; i < 14; i++) begin
            din = (i == 0 || i == 2) ? 8'hF0 : 8'h00;
            cycles(1);
            if (!pn_w[1]) lo_b++;
            if (!pn_w[4]) lo_e++;
        end
        chk("retrig low cycles", lo_b, 6);
        chk("non-retrig low cycles", lo_e, 4);

        // DELAY=4 with inversion mask, one-shot disabled.
        din = 8'h5A; cycles(5);
        chk("C match after 4 stages", m_w[2], 1'b1);
        chk("C pulse_n tied high", pn_w[2], 1'b1);

        // Asynchronous reset in the middle of a long pulse.
        din = 8'h00; cycles(12);
        din = 8'hFF; cycles(2);
        chk("D pulse started", pn_w[3], 1'b0);
        cycles(2);
        #1 rst_n = 1'b0;
        #1;
        chk("D async reset pulse_n", pn_w[3], 1'b1);
        chk("D async reset busy", bz_w[3], 1'b0);
        chk("D async reset match", m_w[3], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        chk("D after release edge0 match", m_w[3], 1'b1);
        chk("D after release edge0 pulse_n", pn_w[3], 1'b1);
        cycles(1);
        chk("D after release edge1 pulse_n", pn_w[3], 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    din = 8'hFF;
                    2:       din = 8'hF0;
                    3:       din = 8'h5A;
                    default: din = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            cycles(1);
        end

        @(negedge clk); #1;
        chk("C pulse_n never low", c_low_seen, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
